// File: rtl/oam_dma_engine_if.sv
// Bus bundle between the sprite-DMA engine and the CPU-side memory bus.
// Latency: n/a (wires only). Backpressure: none; cpu_ce paces every transfer step.
// master: the DMA engine (snoops the CPU bus, drives the DMA bus).
// slave : the system side (CPU snoop, mapper read data, top-level bus mux).
//
// Signals:
//   cpu_ce        one-cycle pulse per CPU cycle
//   cpu_addr      snooped CPU address
//   cpu_WE        snooped CPU write strobe
//   cpu_data      snooped CPU write data (source page on a trigger)
//   dma_data_in   mapper read data for dma_addr, valid in the same cycle
//   cpu_halt      1 while the engine owns the bus
//   dma_addr      DMA bus address
//   dma_WE        DMA write strobe
//   dma_data_out  DMA write data
//   dma_done      one-ce-cycle pulse after the last OAM write
interface oam_dma_engine_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_WE;
  logic [7:0]  cpu_data;
  logic [7:0]  dma_data_in;
  logic        cpu_halt;
  logic [15:0] dma_addr;
  logic        dma_WE;
  logic [7:0]  dma_data_out;
  logic        dma_done;

  modport master (
    input  cpu_ce, cpu_addr, cpu_WE, cpu_data, dma_data_in,
    output cpu_halt, dma_addr, dma_WE, dma_data_out, dma_done
  );

  modport slave (
    output cpu_ce, cpu_addr, cpu_WE, cpu_data, dma_data_in,
    input  cpu_halt, dma_addr, dma_WE, dma_data_out, dma_done
  );
endinterface

// File: rtl/oam_dma_engine.sv
// Sprite (OAM) DMA: on a CPU write to DMA_REG_ADDR, halt the CPU and copy a page into OAMDATA.
// Latency: outputs registered, one ce-cycle behind state; 1 + parity + 2*XFER_LEN ce cycles per transfer.
// Backpressure: none; every step waits for cpu_ce, and all state and outputs hold while cpu_ce=0.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    oam_dma_engine_if.master (CPU snoop inputs, mapper read data, DMA bus outputs)
module oam_dma_engine #(
  parameter int unsigned XFER_LEN      = 256,
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic             clk,
  input  logic             reset,
  oam_dma_engine_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic        parity_q, parity_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  byte_buf_q, byte_buf_d;
  logic        cpu_halt_q, cpu_halt_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic        dma_we_q, dma_we_d;
  logic        dma_done_q, dma_done_d;

  logic trigger;
  assign trigger = bus.cpu_WE && (bus.cpu_addr == DMA_REG_ADDR);

  // Outputs are registered, so each branch computes the bus values for the
  // state being entered, not the state being left. dma_data_out is simply the
  // byte buffer: it only changes at the close of READ, which is exactly when
  // the WRITE that presents it begins.
  always_comb begin
    state_d    = state_q;
    parity_d   = parity_q;
    page_d     = page_q;
    idx_d      = idx_q;
    byte_buf_d = byte_buf_q;
    cpu_halt_d = cpu_halt_q;
    dma_addr_d = dma_addr_q;
    dma_we_d   = dma_we_q;
    dma_done_d = dma_done_q;

    if (bus.cpu_ce) begin
      parity_d   = ~parity_q;
      dma_done_d = 1'b0;

      case (state_q)
        S_IDLE: begin
          // Snooping happens only here; writes while halted cannot retrigger.
          if (trigger) begin
            page_d     = bus.cpu_data;
            idx_d      = 8'd0;
            cpu_halt_d = 1'b1;
            state_d    = S_HALT;
          end
        end

        S_HALT: begin
          // parity_q=1 means this HALT cycle is odd; reads must start on an
          // even cycle, so burn one more cycle in ALIGN.
          if (parity_q) begin
            state_d = S_ALIGN;
          end else begin
            dma_addr_d = {page_q, idx_q};
            dma_we_d   = 1'b0;
            state_d    = S_READ;
          end
        end

        S_ALIGN: begin
          dma_addr_d = {page_q, idx_q};
          dma_we_d   = 1'b0;
          state_d    = S_READ;
        end

        S_READ: begin
          // The mapper answers dma_addr combinationally within this cycle.
          byte_buf_d = bus.dma_data_in;
          dma_addr_d = OAM_DATA_ADDR;
          dma_we_d   = 1'b1;
          state_d    = S_WRITE;
        end

        S_WRITE: begin
          dma_we_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            // dma_done rises together with the release of the CPU.
            dma_done_d = 1'b1;
            cpu_halt_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            // Page never increments: the read address stays within {page,8'hxx}.
            idx_d      = idx_q + 8'd1;
            dma_addr_d = {page_q, idx_q + 8'd1};
            state_d    = S_READ;
          end
        end

        default: begin
          cpu_halt_d = 1'b0;
          dma_we_d   = 1'b0;
          state_d    = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      parity_q   <= 1'b0;
      page_q     <= 8'd0;
      idx_q      <= 8'd0;
      byte_buf_q <= 8'd0;
      cpu_halt_q <= 1'b0;
      dma_addr_q <= 16'd0;
      dma_we_q   <= 1'b0;
      dma_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      parity_q   <= parity_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      byte_buf_q <= byte_buf_d;
      cpu_halt_q <= cpu_halt_d;
      dma_addr_q <= dma_addr_d;
      dma_we_q   <= dma_we_d;
      dma_done_q <= dma_done_d;
    end
  end

  assign bus.cpu_halt     = cpu_halt_q;
  assign bus.dma_addr     = dma_addr_q;
  assign bus.dma_WE       = dma_we_q;
  assign bus.dma_data_out = byte_buf_q;
  assign bus.dma_done     = dma_done_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
`timescale 1ns/1ps
module tb_oam_dma_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oam_dma_engine_if bus_if();

  oam_dma_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Source memory: every page holds byte = low address ^ A5.
  always_comb bus_if.dma_data_in = bus_if.dma_addr[7:0] ^ 8'hA5;

  int errors = 0;
  int checks = 0;
  int ce_cnt = 0;
  int halt_cnt = 0;

  // Expected output state, maintained by the bench.
  logic        e_halt;
  logic [15:0] e_addr;
  logic        e_we;
  logic [7:0]  e_dout;
  logic        e_done;

  typedef struct {
    bit          ce;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        x_halt;
    logic [15:0] x_addr;
    logic        x_we;
    logic [7:0]  x_dout;
    logic        x_done;
    string       name;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] act_v();
    return {5'd0, bus_if.cpu_halt, bus_if.dma_addr, bus_if.dma_WE,
            bus_if.dma_data_out, bus_if.dma_done};
  endfunction

  function automatic logic [31:0] exp_v();
    return {5'd0, e_halt, e_addr, e_we, e_dout, e_done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_exp_zero();
    e_halt = 1'b0; e_addr = 16'h0000; e_we = 1'b0; e_dout = 8'h00; e_done = 1'b0;
  endtask

  // One clock; inputs driven at negedge, outputs sampled 1ns after posedge.
  task automatic tick(input bit ce, input bit we, input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_if.cpu_ce   = ce;
    bus_if.cpu_WE   = we;
    bus_if.cpu_addr = addr;
    bus_if.cpu_data = data;
    @(posedge clk);
    #1;
    if (ce) ce_cnt++;
    bus_if.cpu_ce = 1'b0;
    bus_if.cpu_WE = 1'b0;
  endtask

  // Idle gap clocks (outputs must hold), then one ce cycle.
  task automatic ce_tick(input bit wr, input logic [7:0] data, input int gap);
    for (int g = 0; g < gap; g++) begin
      tick(1'b0, 1'b0, 16'h0000, 8'h00);
      check("gap_hold", act_v(), exp_v());
    end
    if (bus_if.cpu_halt) halt_cnt++;
    tick(1'b1, wr, wr ? 16'h4014 : 16'h0000, data);
  endtask

  function automatic int pick_gap(input int maxgap);
    return (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
  endfunction

  // Full transfer from 'page'. want_align selects HALT parity. inject adds
  // $4014 writes mid-transfer and on the final WRITE. abort_idx>=0 returns
  // right after entering READ of that index.
  task automatic do_transfer(input logic [7:0] page, input bit want_align,
                             input int maxgap, input bit inject, input int abort_idx);
    // Trigger edge is ce number ce_cnt+1; parity in HALT equals its oddness.
    if (ce_cnt[0] == want_align) begin
      ce_tick(1'b0, 8'h00, pick_gap(maxgap));
      check("filler_idle", act_v(), exp_v());
    end
    halt_cnt = 0;
    ce_tick(1'b1, page, pick_gap(maxgap));
    e_halt = 1'b1; e_we = 1'b0; e_done = 1'b0;
    check("halt_entry", act_v(), exp_v());
    if (want_align) begin
      ce_tick(1'b0, 8'h00, pick_gap(maxgap));
      check("align", act_v(), exp_v());
    end
    for (int i = 0; i < 256; i++) begin
      ce_tick(inject && (i == 50), 8'h07, pick_gap(maxgap));
      e_addr = {page, 8'(i)}; e_we = 1'b0;
      check("read", act_v(), exp_v());
      if (i == abort_idx) return;
      ce_tick(1'b0, 8'h00, pick_gap(maxgap));
      e_addr = 16'h2004; e_we = 1'b1; e_dout = 8'(i) ^ 8'hA5;
      check("write", act_v(), exp_v());
    end
    // This ce closes the final WRITE; a trigger here must be ignored.
    ce_tick(inject, 8'h07, pick_gap(maxgap));
    e_halt = 1'b0; e_we = 1'b0; e_done = 1'b1;
    check("done", act_v(), exp_v());
    check("halt_cycles", 32'(halt_cnt), want_align ? 32'd514 : 32'd513);
    ce_tick(1'b0, 8'h00, pick_gap(maxgap));
    e_done = 1'b0;
    check("idle_after", act_v(), exp_v());
  endtask

  task automatic async_reset(input string name);
    #3 reset = 1'b0;
    #1;
    set_exp_zero();
    check(name, act_v(), exp_v());
    @(negedge clk);
    reset = 1'b1;
    ce_cnt = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 16'h4015, 8'h02, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, "no_trig_addr"};
    vecs[1] = '{1'b1, 1'b0, 16'h4014, 8'h02, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, "no_trig_read"};
    vecs[2] = '{1'b0, 1'b1, 16'h4014, 8'h03, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, "no_trig_noce"};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, "idle"};
    vecs[4] = '{1'b1, 1'b1, 16'h4014, 8'h03, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, "trigger"};
    vecs[5] = '{1'b1, 1'b1, 16'h4014, 8'h07, 1'b1, 16'h0300, 1'b0, 8'h00, 1'b0, "read0"};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0300, 1'b0, 8'h00, 1'b0, "ce_low_hold"};
    vecs[7] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h2004, 1'b1, 8'hA5, 1'b0, "write0"};
    vecs[8] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0301, 1'b0, 8'hA5, 1'b0, "read1"};
    vecs[9] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h2004, 1'b1, 8'hA4, 1'b0, "write1"};

    bus_if.cpu_ce   = 1'b0;
    bus_if.cpu_WE   = 1'b0;
    bus_if.cpu_addr = 16'h0000;
    bus_if.cpu_data = 8'h00;
    reset = 1'b0;
    set_exp_zero();
    #12;
    check("reset_state", act_v(), exp_v());
    @(negedge clk);
    reset = 1'b1;
    ce_cnt = 0;

    // Table-driven single ce steps from reset (parity 0 at the trigger).
    for (int v = 0; v < 10; v++) begin
      tick(vecs[v].ce, vecs[v].we, vecs[v].addr, vecs[v].data);
      check(vecs[v].name, act_v(),
            {5'd0, vecs[v].x_halt, vecs[v].x_addr, vecs[v].x_we, vecs[v].x_dout, vecs[v].x_done});
    end
    async_reset("reset_abort_table");

    do_transfer(8'h02, 1'b0, 0, 1'b0, -1);   // even parity: 513 cycles
    do_transfer(8'h02, 1'b1, 0, 1'b0, -1);   // odd parity: ALIGN, 514 cycles
    do_transfer(8'h02, 1'b0, 3, 1'b0, -1);   // random ce gaps
    do_transfer(8'h02, 1'b0, 0, 1'b1, -1);   // ignored $4014 writes
    do_transfer(8'h21, 1'b1, 1, 1'b0, -1);   // PPU-register page is legal

    do_transfer(8'h02, 1'b0, 0, 1'b0, 100);  // stop in READ of idx 100
    async_reset("reset_mid_transfer");
    do_transfer(8'h02, 1'b1, 0, 1'b0, -1);   // fresh start from idx 0

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
